// File: rtl/tt_seq_alu_pkg.sv
// tt_seq_alu_pkg: opcode and FSM state encodings shared by the sequential ALU core
// and its testbench.
package tt_seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_MUL = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tt_seq_alu_mul.sv
// tt_seq_alu_mul: start/last shift-add unsigned multiplier, one partial product per
// enabled cycle. 'start' loads the operands and the step counter with WIDTH; each
// following enabled cycle adds one partial product. 'last' is high during the final
// step, and product_nxt then holds the complete product.
module tt_seq_alu_mul #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 last,
  output logic [2*WIDTH-1:0]   product_nxt
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  // Next partial sum, load on start, one shift-add step per enabled cycle.
  always_comb begin
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    product_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    last        = (cnt_q == CW'(1));
    if (ena) begin
      if (start) begin
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, a};
        mplier_d = b;
        cnt_d    = CW'(WIDTH);
      end else if (cnt_q != '0) begin
        acc_d    = product_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
      end
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/tt_seq_alu.sv
// tt_seq_alu: sequential ALU core. Single-cycle ops finish at accept; MUL runs a
// WIDTH-cycle shift-add in tt_seq_alu_mul. Result and flags are held until consumed.
// Optional accumulator operand source: define TT_SEQ_ALU_ACC_EN.
//
// Handshake: an input transfer happens on a rising edge where in_valid && in_ready;
// an output transfer happens on a rising edge where out_valid && out_ready. in_ready
// and out_valid depend only on registered state and ena, never on in_valid/out_ready.
module tt_seq_alu
  import tt_seq_alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef TT_SEQ_ALU_ACC_EN
  input  logic                 acc_sel,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 flag_z,
  output logic                 flag_c,
  output logic                 flag_v,
  output logic                 busy
);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               fz_q, fz_d, fc_q, fc_d, fv_q, fv_d;

  op_e                op_sel;
  logic [WIDTH-1:0]   op_a;
  logic               accept;
  logic               mul_start, mul_last;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]     sum_w, dif_w;
  logic [2*WIDTH-1:0] alu_res;
  logic               alu_c, alu_v;

  assign op_sel    = op_e'(op);
  assign in_ready  = ena && (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == EXEC);
  assign result    = result_q;
  assign flag_z    = fz_q;
  assign flag_c    = fc_q;
  assign flag_v    = fv_q;

`ifdef TT_SEQ_ALU_ACC_EN
  logic [WIDTH-1:0] acc_q, acc_d;

  assign op_a = acc_sel ? acc_q : a;

  // Accumulator captures the low result half on every output transfer.
  always_comb begin
    acc_d = acc_q;
    if (ena && out_valid && out_ready) acc_d = result_q[WIDTH-1:0];
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end
`else
  assign op_a = a;
`endif

  // Single-cycle datapath and its carry/overflow flags.
  always_comb begin
    sum_w   = {1'b0, op_a} + {1'b0, b};
    dif_w   = {1'b0, op_a} - {1'b0, b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_sel)
      OP_ADD: begin
        alu_res = {{WIDTH{1'b0}}, sum_w[WIDTH-1:0]};
        alu_c   = sum_w[WIDTH];
        alu_v   = (op_a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = {{WIDTH{1'b0}}, dif_w[WIDTH-1:0]};
        alu_c   = dif_w[WIDTH];
        alu_v   = (op_a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND: alu_res = {{WIDTH{1'b0}}, op_a & b};
      OP_OR:  alu_res = {{WIDTH{1'b0}}, op_a | b};
      OP_XOR: alu_res = {{WIDTH{1'b0}}, op_a ^ b};
      OP_SHL: alu_res = {{WIDTH{1'b0}}, op_a} << b[SHW-1:0];
      OP_CMP: begin
        alu_res = {{(2*WIDTH-1){1'b0}}, dif_w[WIDTH]};
        alu_c   = dif_w[WIDTH];
      end
      default: ;
    endcase
  end

  // FSM next state plus result/flag capture; ena low holds everything.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    fz_d      = fz_q;
    fc_d      = fc_q;
    fv_d      = fv_q;
    mul_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_sel == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = EXEC;
          end else begin
            result_d = alu_res;
            fz_d     = (alu_res == '0);
            fc_d     = alu_c;
            fv_d     = alu_v;
            state_d  = DONE;
          end
        end
      end
      EXEC: begin
        if (ena && mul_last) begin
          result_d = mul_product;
          fz_d     = (mul_product == '0);
          fc_d     = 1'b0;
          fv_d     = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (ena && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, result and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      fz_q     <= 1'b0;
      fc_q     <= 1'b0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      fz_q     <= fz_d;
      fc_q     <= fc_d;
      fv_q     <= fv_d;
    end
  end

  tt_seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .start       (mul_start),
    .a           (op_a),
    .b           (b),
    .last        (mul_last),
    .product_nxt (mul_product)
  );

endmodule

// File: tb/tb_tt_seq_alu.sv
// tb_tt_seq_alu: directed test of tt_seq_alu at WIDTH=4 with hand-computed results.
module tb_tt_seq_alu;
  import tt_seq_alu_pkg::*;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           ena;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           flag_z;
  logic           flag_c;
  logic           flag_v;
  logic           busy;

  int total = 0;
  int bad   = 0;

  tt_seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
`ifdef TT_SEQ_ALU_ACC_EN
    .acc_sel   (1'b0),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .busy      (busy)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Comparison helper.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for exactly one accept edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
    op       = o;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    check("in_ready_before_issue", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Accept the held result and confirm return to IDLE.
  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_after_consume"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_after_consume"}, 32'(in_ready), 32'd1);
  endtask

  // Check result and all three flags.
  task automatic check_res(input string tag, input logic [7:0] r,
                           input logic z, input logic c, input logic v);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(r));
    check({tag, "_z"}, 32'(flag_z), 32'(z));
    check({tag, "_c"}, 32'(flag_c), 32'(c));
    check({tag, "_v"}, 32'(flag_v), 32'(v));
  endtask

  // Directed sequence.
  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 3'b000;
    a         = '0;
    b         = '0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", {29'd0, flag_z, flag_c, flag_v}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ADD 7+9: wraps to zero with carry, latency 1.
    issue(OP_ADD, 4'd7, 4'd9);
    check_res("add_7_9", 8'h00, 1'b1, 1'b1, 1'b0);
    consume("add_7_9");

    // ADD 7+1: signed overflow.
    issue(OP_ADD, 4'd7, 4'd1);
    check_res("add_7_1", 8'h08, 1'b0, 1'b0, 1'b1);
    consume("add_7_1");

    // SUB 3-5: borrow.
    issue(OP_SUB, 4'd3, 4'd5);
    check_res("sub_3_5", 8'h0E, 1'b0, 1'b1, 1'b0);
    consume("sub_3_5");

    // Logic ops.
    issue(OP_AND, 4'hC, 4'hA);
    check_res("and_c_a", 8'h08, 1'b0, 1'b0, 1'b0);
    consume("and");
    issue(OP_OR, 4'h5, 4'h2);
    check_res("or_5_2", 8'h07, 1'b0, 1'b0, 1'b0);
    consume("or");
    issue(OP_XOR, 4'hF, 4'hF);
    check_res("xor_f_f", 8'h00, 1'b1, 1'b0, 1'b0);
    consume("xor");

    // SHL keeps the shifted-out bits in the upper half.
    issue(OP_SHL, 4'hF, 4'd3);
    check_res("shl_f_3", 8'h78, 1'b0, 1'b0, 1'b0);
    consume("shl");

    // CMP 2<9 true, 9<2 false.
    issue(OP_CMP, 4'd2, 4'd9);
    check_res("cmp_2_9", 8'h01, 1'b0, 1'b1, 1'b0);
    consume("cmp_2_9");
    issue(OP_CMP, 4'd9, 4'd2);
    check_res("cmp_9_2", 8'h00, 1'b1, 1'b0, 1'b0);
    consume("cmp_9_2");

    // MUL 15*15: busy 4 cycles, out_valid in the 5th cycle after accept.
    issue(OP_MUL, 4'd15, 4'd15);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("mul_busy_c%0d", i), 32'(busy), 32'd1);
      check($sformatf("mul_in_ready_c%0d", i), 32'(in_ready), 32'd0);
      check($sformatf("mul_out_valid_c%0d", i), 32'(out_valid), 32'd0);
      tick();
    end
    check_res("mul_f_f", 8'hE1, 1'b0, 1'b0, 1'b0);
    check("mul_busy_done", 32'(busy), 32'd0);
    consume("mul");

    // Backpressure on ADD 1+2, with a stray in_valid that must be ignored.
    issue(OP_ADD, 4'd1, 4'd2);
    check_res("bp_add", 8'h03, 1'b0, 1'b0, 1'b0);
    op       = OP_ADD;
    a        = 4'd5;
    b        = 4'd5;
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("bp_result_c%0d", i), 32'(result), 32'h03);
      check($sformatf("bp_in_ready_c%0d", i), 32'(in_ready), 32'd0);
      check($sformatf("bp_out_valid_c%0d", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    consume("bp");

    // ena=0 during EXEC freezes the multiplier: MUL 3*5 = 0x0F.
    issue(OP_MUL, 4'd3, 4'd5);
    tick();
    ena = 1'b0;
    check("ena_low_in_ready", 32'(in_ready), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("ena_frozen_busy_c%0d", i), 32'(busy), 32'd1);
      check($sformatf("ena_frozen_out_valid_c%0d", i), 32'(out_valid), 32'd0);
    end
    ena = 1'b1;
    tick();
    check("ena_resume_busy1", 32'(busy), 32'd1);
    tick();
    check("ena_resume_busy2", 32'(busy), 32'd1);
    tick();
    check_res("ena_mul_3_5", 8'h0F, 1'b0, 1'b0, 1'b0);
    ena = 1'b0;
    out_ready = 1'b1;
    tick();
    check("ena_low_holds_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    ena = 1'b1;
    consume("ena");

    // Reset in cycle 2 of a MUL discards it.
    issue(OP_MUL, 4'd15, 4'd15);
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    check("postrst_out_valid", 32'(out_valid), 32'd0);
    issue(OP_ADD, 4'd4, 4'd4);
    check_res("postrst_add_4_4", 8'h08, 1'b0, 1'b0, 1'b1);
    consume("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
